// File: rtl/park_gate_arbiter.sv
// park_gate_arbiter: sequencer/arbiter for the car park's single shared barrier.
// Arbitrates exit and entry lanes (exit always wins), gates entry behind a
// two-digit password, and tracks occupancy against CAPACITY without wrapping.
//
// Optional feature macro: PARK_TIMEOUT_EN
//   defined   -> WAIT_PASS/WRONG give up after TIMEOUT cycles without pass_valid
//   undefined -> WAIT_PASS/WRONG wait until pass_valid or entry_req drops
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | barrier closed, arbitrating exit_req / entry_req
// WAIT_PASS | entry car waiting for the password strobe
// ENTER     | barrier open for the entry lane, waiting for gate_done
// EXIT      | barrier open for the exit lane, waiting for gate_done
// WRONG     | last password was wrong, red LED on, waiting for a retry
module park_gate_arbiter #(
  parameter int         CAPACITY = 8,
  parameter int         CNT_W    = 4,
  parameter logic [1:0] PASS_1   = 2'b01,
  parameter logic [1:0] PASS_2   = 2'b10,
  parameter int         TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [1:0]       password_1,
  input  logic [1:0]       password_2,
  input  logic             pass_valid,
  input  logic             gate_done,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             green_led,
  output logic             red_led
);

  // Reject parameter sets the counter cannot represent.
  if (CAPACITY < 1 || CAPACITY > (2**CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_param
    $error("park_gate_arbiter: CAPACITY must be 1..2**CNT_W-1 and TIMEOUT >= 1");
  end

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PASS = 3'd1,
    ENTER     = 3'd2,
    EXIT      = 3'd3,
    WRONG     = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_occ;
  logic             r_full;

  logic             w_pass_ok;
  logic [CNT_W-1:0] w_occ_inc;
  logic [CNT_W-1:0] w_occ_dec;

  assign w_pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);
  assign w_occ_inc = r_occ + 1'b1;
  assign w_occ_dec = r_occ - 1'b1;

`ifdef PARK_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  // Down-counter reaching zero on the last of TIMEOUT password-wait cycles.
  logic [TMR_W-1:0] r_tmr;
`endif

  // Main sequencer: lane arbitration, password check and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_occ   <= '0;
      r_full  <= 1'b0;
`ifdef PARK_TIMEOUT_EN
      r_tmr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // Exit first so a full lot can always drain.
          if (exit_req && (r_occ != '0)) begin
            r_state <= EXIT;
          end else if (entry_req && !r_full) begin
            r_state <= WAIT_PASS;
`ifdef PARK_TIMEOUT_EN
            r_tmr   <= TMR_LOAD;
`endif
          end
        end

        WAIT_PASS, WRONG: begin
          // pass_valid outranks a simultaneous entry_req drop.
          if (pass_valid) begin
            if (w_pass_ok) begin
              r_state <= ENTER;
            end else begin
              r_state <= WRONG;
`ifdef PARK_TIMEOUT_EN
              r_tmr   <= TMR_LOAD;
`endif
            end
          end else if (!entry_req) begin
            r_state <= IDLE;
`ifdef PARK_TIMEOUT_EN
          end else if (r_tmr == '0) begin
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
`endif
          end
        end

        ENTER: begin
          if (gate_done) begin
            r_state <= IDLE;
            if (r_occ != CAP) begin
              r_occ  <= w_occ_inc;
              r_full <= (w_occ_inc == CAP);
            end
          end
        end

        EXIT: begin
          if (gate_done) begin
            r_state <= IDLE;
            if (r_occ != '0) begin
              r_occ  <= w_occ_dec;
              r_full <= 1'b0;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Barrier and LED drive decoded straight from the state register.
  assign gate_open = (r_state == ENTER) || (r_state == EXIT);
  assign gate_dir  = (r_state == ENTER);
  assign green_led = gate_open;
  assign occupancy = r_occ;
  assign full      = r_full;
  assign red_led   = (r_state == WRONG) || ((r_state == IDLE) && r_full && entry_req);

endmodule

// File: tb/tb_park_gate_arbiter.sv
// Self-checking bench for park_gate_arbiter (default build, PARK_TIMEOUT_EN undefined).
// Directed scenarios followed by random traffic, all compared against a
// flag-based model of the lot and barrier.
module tb_park_gate_arbiter;

  localparam int CAP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req, exit_req;
  logic [1:0] password_1, password_2;
  logic       pass_valid, gate_done;
  logic       gate_open, gate_dir, full, green_led, red_led;
  logic [3:0] occupancy;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: occupancy count plus what the barrier is currently doing.
  int m_occ;
  bit m_in_entry;
  bit m_in_exit;
  bit m_asking;
  bit m_refused;

  park_gate_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .password_1 (password_1),
    .password_2 (password_2),
    .pass_valid (pass_valid),
    .gate_done  (gate_done),
    .gate_open  (gate_open),
    .gate_dir   (gate_dir),
    .occupancy  (occupancy),
    .full       (full),
    .green_led  (green_led),
    .red_led    (red_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ      = 0;
    m_in_entry = 0;
    m_in_exit  = 0;
    m_asking   = 0;
    m_refused  = 0;
  endtask

  // One clock edge of lot behaviour, using the inputs presented at that edge.
  task automatic model_step();
    bit good;
    good = (password_1 == 2'd1) && (password_2 == 2'd2);
    if (m_in_exit) begin
      if (gate_done) begin
        m_in_exit = 0;
        if (m_occ > 0) m_occ = m_occ - 1;
      end
    end else if (m_in_entry) begin
      if (gate_done) begin
        m_in_entry = 0;
        if (m_occ < CAP) m_occ = m_occ + 1;
      end
    end else if (m_asking || m_refused) begin
      if (pass_valid) begin
        m_asking   = 0;
        m_refused  = !good;
        m_in_entry = good;
      end else if (!entry_req) begin
        m_asking  = 0;
        m_refused = 0;
      end
    end else begin
      if (exit_req && m_occ > 0)        m_in_exit = 1;
      else if (entry_req && m_occ < CAP) m_asking = 1;
    end
  endtask

  task automatic check_outputs();
    bit busy;
    bit idle;
    busy = m_in_entry || m_in_exit;
    idle = !busy && !m_asking && !m_refused;
    chk("gate_open", 32'(gate_open), 32'(busy));
    chk("gate_dir",  32'(gate_dir),  32'(m_in_entry));
    chk("green_led", 32'(green_led), 32'(busy));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("full",      32'(full),      32'(m_occ == CAP));
    chk("red_led",   32'(red_led),   32'(m_refused || (idle && m_occ == CAP && entry_req)));
  endtask

  // Present inputs on the falling edge, step model on the rising edge, check next falling edge.
  task automatic cyc(input bit e, input bit x, input logic [1:0] a, input logic [1:0] b,
                     input bit pv, input bit gd);
    entry_req  = e;
    exit_req   = x;
    password_1 = a;
    password_2 = b;
    pass_valid = pv;
    gate_done  = gd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic exit_one();
    cyc(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic enter_one();
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    password_1 = 2'd0;
    password_2 = 2'd0;
    pass_valid = 1'b0;
    gate_done  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    @(negedge clk);

    // Correct password entry.
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t1_open", 32'(gate_open), 32'd1);
    chk("t1_dir",  32'(gate_dir),  32'd1);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("t1_occ",  32'(occupancy), 32'd1);
    chk("t1_shut", 32'(gate_open), 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Wrong password, then retry.
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0);
    chk("t2_red", 32'(red_led), 32'd1);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t2_red_off", 32'(red_led),   32'd0);
    chk("t2_green",   32'(green_led), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Fill the lot, then refused entry, then one exit.
    for (int i = 0; i < 20 && m_occ < CAP; i++) enter_one();
    chk("t3_occ8", 32'(occupancy), 32'd8);
    chk("t3_full", 32'(full),      32'd1);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("t3_refused_open", 32'(gate_open), 32'd0);
    chk("t3_refused_red",  32'(red_led),   32'd1);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t3_no_grant", 32'(gate_open), 32'd0);
    exit_one();
    chk("t3_occ7",   32'(occupancy), 32'd7);
    chk("t3_unfull", 32'(full),      32'd0);

    // Exit priority over simultaneous entry.
    for (int i = 0; i < 10 && m_occ > 3; i++) exit_one();
    cyc(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("t4_open", 32'(gate_open), 32'd1);
    chk("t4_dir",  32'(gate_dir),  32'd0);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("t4_occ2", 32'(occupancy), 32'd2);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t4_entry_next", 32'(gate_dir), 32'd1);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);

    // Exit at zero occupancy, stray gate_done.
    for (int i = 0; i < 10 && m_occ > 0; i++) exit_one();
    cyc(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("t5_no_exit", 32'(gate_open), 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("t5_occ0", 32'(occupancy), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("t5_done_in_wait", 32'(occupancy), 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e, x, pv, gd;
      logic [1:0] a, b;
      e  = ($urandom_range(0, 99) < 70);
      x  = ($urandom_range(0, 99) < 25);
      pv = ($urandom_range(0, 99) < 30);
      gd = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 99) < 60) begin
        a = 2'd1;
        b = 2'd2;
      end else begin
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
      end
      cyc(e, x, a, b, pv, gd);
    end

    // Reset in the middle of an entry grant.
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && m_occ > CAP - 2; i++) exit_one();
    enter_one();
    cyc(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("t6_granted", 32'(gate_open), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_open", 32'(gate_open), 32'd0);
    chk("t6_async_occ",  32'(occupancy), 32'd0);
    chk("t6_async_grn",  32'(green_led), 32'd0);
    model_reset();
    entry_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/park_gate_arbiter.md
# park_gate_arbiter

Sequencer and arbiter for the car park's single shared barrier gate. It accepts entrance and exit sensor requests, gates entry behind a two-digit password check, grants the barrier to one lane at a time, and tracks lot occupancy against a fixed capacity. It sits between the lane sensors/keypad and the barrier actuator, driving the status LEDs.

## Interface
- CAPACITY, 8: number of spaces; 1..2**CNT_W-1
- CNT_W, 4: occupancy counter width
- PASS_1, 2'b01: required password_1 digit
- PASS_2, 2'b10: required password_2 digit
- TIMEOUT, 16: password wait limit in cycles (used only with PARK_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- entry_req  in  1  level, car present at entrance sensor
- exit_req  in  1  level, car present at exit sensor
- password_1  in  2  first password digit
- password_2  in  2  second password digit
- pass_valid  in  1  one-cycle strobe; passwords sampled this cycle
- gate_done  in  1  one-cycle pulse from barrier: vehicle cleared
- gate_open  out  1  barrier open command
- gate_dir  out  1  1 = entry lane granted, 0 = exit lane
- occupancy  out  CNT_W  cars currently inside
- full  out  1  occupancy == CAPACITY
- green_led  out  1  barrier granted
- red_led  out  1  wrong password or entry refused

## Operation
- States: IDLE, WAIT_PASS, ENTER, EXIT, WRONG. Reset state IDLE.
- IDLE: exit_req && occupancy != 0 -> EXIT (exit has priority over entry, always). Else entry_req && !full -> WAIT_PASS. exit_req with occupancy 0 ignored.
- WAIT_PASS: pass_valid with password_1==PASS_1 && password_2==PASS_2 -> ENTER; pass_valid with mismatch -> WRONG; entry_req low -> IDLE. Exit requests do not preempt.
- WRONG: matching pass_valid -> ENTER; mismatching pass_valid -> stay; entry_req low -> IDLE.
- ENTER: gate_open=1, gate_dir=1, green_led=1; gate_done -> occupancy+1, -> IDLE.
- EXIT: gate_open=1, gate_dir=0, green_led=1; gate_done -> occupancy-1, -> IDLE.
- gate_done outside ENTER/EXIT ignored; pass_valid outside WAIT_PASS/WRONG ignored.
- Occupancy never exceeds CAPACITY (entry refused when full) and never underflows (exit refused at 0); no wrap.
- red_led = (state==WRONG) || (state==IDLE && full && entry_req); only combinational output.
- Simultaneous pass_valid and entry_req falling in WAIT_PASS/WRONG: pass_valid wins.

## Timing
- Reset values: gate_open 0, gate_dir 0, occupancy 0, full 0, green_led 0, red_led 0 (with entry_req low).
- gate_open, gate_dir, green_led decoded from the state register; occupancy and full registered.
- Request sampled in IDLE at edge N -> gate_open high after edge N (EXIT) or WAIT_PASS entered after edge N.
- pass_valid sampled at edge N -> gate_open high after edge N.
- gate_done sampled at edge N -> gate_open low and occupancy/full updated after edge N, same cycle.
- At least one IDLE cycle with gate_open low between consecutive grants.
- Reset asserted mid-grant: gate_open drops immediately (asynchronous), occupancy cleared to 0.

## Configuration
- PARK_TIMEOUT_EN defined: a TIMEOUT-cycle counter starts on entry to WAIT_PASS or WRONG and is cleared by pass_valid. It expires when TIMEOUT cycles elapse without pass_valid, moving the state to IDLE. The IDLE cycle permits re-arbitration, so a waiting exit_req is served next.
- Undefined: no counter; WAIT_PASS/WRONG wait indefinitely until pass_valid or entry_req drops.

## Test plan
- Reset, entry_req=1, pass_valid with 1/2 -> gate_open=1, gate_dir=1 next cycle; gate_done -> occupancy=1, gate_open=0.
- Entry with password 3/0 -> red_led=1 in WRONG; then 1/2 -> ENTER, red_led=0, green_led=1.
- Fill to CAPACITY=8 -> full=1; further entry_req -> stays IDLE, red_led=1; exit_req + gate_done -> occupancy=7, full=0.
- entry_req and exit_req both high in IDLE with occupancy=3 -> EXIT granted first (gate_dir=0); after gate_done, entry proceeds to WAIT_PASS.
- exit_req with occupancy=0 -> no grant; gate_done pulses in IDLE -> occupancy unchanged.
- With PARK_TIMEOUT_EN and TIMEOUT=16: entry_req held, no pass_valid for 16 cycles -> IDLE; reset mid-ENTER -> gate_open=0 and occupancy=0 immediately.
